// File: rtl/axi4_lite_pkg.sv
// Shared definitions for the two-requester AXI4-Lite master arbiter:
// FSM state encoding, AXI response codes and default bus widths.
package axi4_lite_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_ADDR_WIDTH = 32;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_BRESP = 3'd2,
        S_RADDR = 3'd3,
        S_RDATA = 3'd4,
        S_RSP   = 3'd5
    } state_t;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter: combinational one-hot grant, with the
// tie-break pointer moving only when the parent accepts the grant.
module rr_arbiter_2 (
    input  logic       ACLK,
    input  logic       ARESETn,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    // prio_q names the requester favoured in the next tie, i.e. the one
    // that was not granted last; zero after reset so requester 0 wins first.
    logic prio_q;
    logic prio_d;

    always_comb begin
        grant  = 2'b00;
        prio_d = prio_q;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = prio_q ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
        if (advance && (grant != 2'b00)) begin
            prio_d = grant[0];
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/axi4_lite_req_arbiter.sv
// Arbitrates two simple request ports onto one AXI4-Lite master port,
// running a single transaction at a time and returning a completion pulse.
module axi4_lite_req_arbiter
    import axi4_lite_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                    ACLK,
    input  logic                    ARESETn,

    input  logic [1:0]              REQ_VALID,
    input  logic [1:0]              REQ_WRITE,
    input  logic [2*ADDR_WIDTH-1:0] REQ_ADDR,
    input  logic [2*DATA_WIDTH-1:0] REQ_WDATA,
    input  logic [2*STRB_WIDTH-1:0] REQ_WSTRB,
    output logic [1:0]              REQ_READY,
    output logic [1:0]              RSP_VALID,
    output logic [DATA_WIDTH-1:0]   RSP_RDATA,
    output logic [1:0]              RSP_RESP,

    output logic                    M_AXI_AWVALID,
    input  logic                    M_AXI_AWREADY,
    output logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic                    M_AXI_WVALID,
    input  logic                    M_AXI_WREADY,
    output logic [DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [STRB_WIDTH-1:0]   M_AXI_WSTRB,
    input  logic                    M_AXI_BVALID,
    output logic                    M_AXI_BREADY,
    input  logic [1:0]              M_AXI_BRESP,
    output logic                    M_AXI_ARVALID,
    input  logic                    M_AXI_ARREADY,
    output logic [ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    input  logic                    M_AXI_RVALID,
    output logic                    M_AXI_RREADY,
    input  logic [DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]              M_AXI_RRESP
);

    logic [ADDR_WIDTH-1:0] req_addr_arr  [2];
    logic [DATA_WIDTH-1:0] req_wdata_arr [2];
    logic [STRB_WIDTH-1:0] req_wstrb_arr [2];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_unpack
            assign req_addr_arr[gi]  = REQ_ADDR[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign req_wdata_arr[gi] = REQ_WDATA[gi*DATA_WIDTH +: DATA_WIDTH];
            assign req_wstrb_arr[gi] = REQ_WSTRB[gi*STRB_WIDTH +: STRB_WIDTH];
        end
    endgenerate

    state_t                state_q, state_d;
    logic [1:0]            gnt_q, gnt_d;
    logic                  write_q, write_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
    logic                  aw_done_q, aw_done_d;
    logic                  w_done_q, w_done_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [1:0]            rsp_resp_q, rsp_resp_d;
    // run_q holds off granting until the first clock edge after reset release.
    logic                  run_q, run_d;

    logic [1:0]            arb_grant;
    logic                  arb_advance;
    logic [1:0]            req_ready;
    logic                  req_sel;

    rr_arbiter_2 u_rr_arbiter_2 (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .req     (REQ_VALID),
        .advance (arb_advance),
        .grant   (arb_grant)
    );

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        write_d     = write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;
        run_d       = 1'b1;
        arb_advance = 1'b0;
        req_ready   = 2'b00;
        req_sel     = arb_grant[1];

        case (state_q)
            S_IDLE: begin
                if (run_q && (arb_grant != 2'b00)) begin
                    req_ready   = arb_grant;
                    arb_advance = 1'b1;
                    gnt_d       = arb_grant;
                    write_d     = REQ_WRITE[req_sel];
                    addr_d      = req_addr_arr[req_sel];
                    wdata_d     = req_wdata_arr[req_sel];
                    wstrb_d     = req_wstrb_arr[req_sel];
                    aw_done_d   = 1'b0;
                    w_done_d    = 1'b0;
                    state_d     = REQ_WRITE[req_sel] ? S_WRITE : S_RADDR;
                end
            end
            S_WRITE: begin
                aw_done_d = aw_done_q | M_AXI_AWREADY;
                w_done_d  = w_done_q | M_AXI_WREADY;
                if (aw_done_d && w_done_d) begin
                    state_d = S_BRESP;
                end
            end
            S_BRESP: begin
                if (M_AXI_BVALID) begin
                    rsp_resp_d = M_AXI_BRESP;
                    state_d    = S_RSP;
                end
            end
            S_RADDR: begin
                if (M_AXI_ARREADY) begin
                    state_d = S_RDATA;
                end
            end
            S_RDATA: begin
                if (M_AXI_RVALID) begin
                    rsp_rdata_d = M_AXI_RDATA;
                    rsp_resp_d  = M_AXI_RRESP;
                    state_d     = S_RSP;
                end
            end
            S_RSP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q     <= S_IDLE;
            gnt_q       <= 2'b00;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= 2'b00;
            run_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
            run_q       <= run_d;
        end
    end

    // AXI handshake outputs come purely from flops, never from inputs.
    assign M_AXI_AWVALID = (state_q == S_WRITE) && write_q && !aw_done_q;
    assign M_AXI_WVALID  = (state_q == S_WRITE) && write_q && !w_done_q;
    assign M_AXI_BREADY  = (state_q == S_BRESP);
    assign M_AXI_ARVALID = (state_q == S_RADDR);
    assign M_AXI_RREADY  = (state_q == S_RDATA);

    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = wstrb_q;

    assign REQ_READY     = req_ready;
    assign RSP_VALID     = (state_q == S_RSP) ? gnt_q : 2'b00;
    assign RSP_RDATA     = rsp_rdata_q;
    assign RSP_RESP      = rsp_resp_q;

endmodule
